// File: rtl/mdim_rr_sched.sv
// mdim_rr_sched
// Round-robin scheduler that shares one downstream multidim datapath stage
// between NREQ requesters. One requester is selected per beat and its beat
// (packed byte-array data plus a small meta word) is registered into a
// single output slot with a valid/ready handshake. A requester can hold the
// stage for a multi-beat burst by setting the top meta bit (lock flag). A
// burst is capped at MAX_LOCK beats so one requester cannot starve the rest.
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   req_valid  per-requester beat valid
//   req_ready  per-requester accept (one-hot or zero)
//   req_data   per-requester data beat [NREQ][NBYTES][BYTEW]
//   req_meta   per-requester meta word; bit METAW-1 is the lock flag
//   out_valid  output slot holds a beat
//   out_ready  downstream accept
//   out_data   registered data beat
//   out_meta   registered meta word
//   out_src    index of the requester that supplied the current beat
//   locked     burst lock active
module mdim_rr_sched #(
  parameter int NREQ     = 4,
  parameter int NBYTES   = 32,
  parameter int BYTEW    = 8,
  parameter int METAW    = 5,
  parameter int MAX_LOCK = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NREQ-1:0]                           req_valid,
  output logic [NREQ-1:0]                           req_ready,
  input  logic [NREQ-1:0][NBYTES-1:0][BYTEW-1:0]    req_data,
  input  logic [NREQ-1:0][METAW-1:0]                req_meta,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [NBYTES-1:0][BYTEW-1:0]              out_data,
  output logic [METAW-1:0]                          out_meta,
  output logic [$clog2(NREQ)-1:0]                   out_src,
  output logic                                      locked
);

  localparam int IDXW     = $clog2(NREQ);
  localparam int CNTW     = $clog2(MAX_LOCK + 1);
  localparam bit CAN_LOCK = (MAX_LOCK > 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDXW-1:0]   owner;
  logic [IDXW-1:0]   owner_nxt;
  logic [CNTW-1:0]   lock_cnt;
  logic [CNTW-1:0]   cnt_nxt;
  logic [CNTW-1:0]   cnt_inc;
  logic [IDXW-1:0]   rr_ptr;

  logic              load;
  logic              grant_any;
  logic [IDXW-1:0]   grant_idx;
  logic [IDXW-1:0]   cand;
  logic              grant_lock;

  // The slot can take a new beat when it is empty or is being popped this
  // cycle, which gives one beat per cycle with out_ready held high.
  assign load       = !out_valid || out_ready;
  assign grant_lock = req_meta[grant_idx][METAW-1];
  assign locked     = (state == LOCKED);

  // Grant selection. While locked only the owner is eligible, even if it is
  // idle, so the slot drains and bubbles instead of interleaving a packet.
  // Otherwise search starts one past the last winner and wraps around.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    req_ready = '0;
    if (!reset && load) begin
      if (state == LOCKED) begin
        if (req_valid[owner]) begin
          grant_any = 1'b1;
          grant_idx = owner;
        end
      end else begin
        for (int i = 1; i <= NREQ; i++) begin
          cand = IDXW'((int'(rr_ptr) + i) % NREQ);
          if (!grant_any && req_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
          end
        end
      end
    end
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Burst lock next-state. lock_cnt counts beats already sent in the burst;
  // the burst ends on a beat without the lock flag or on the MAX_LOCK-th beat,
  // which is still forwarded with its flag untouched.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = lock_cnt;
    cnt_inc   = lock_cnt + CNTW'(1);
    if (grant_any) begin
      case (state)
        IDLE: begin
          if (grant_lock && CAN_LOCK) begin
            state_nxt = LOCKED;
            owner_nxt = grant_idx;
            cnt_nxt   = CNTW'(1);
          end
        end
        LOCKED: begin
          if (!grant_lock || (cnt_inc == CNTW'(MAX_LOCK))) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = cnt_inc;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and output slot registers. When the slot cannot load it holds
  // every field stable; a load cycle without a transfer leaves a bubble.
  // rr_ptr resets to the last index so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= '0;
      lock_cnt  <= '0;
      rr_ptr    <= IDXW'(NREQ - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_meta  <= '0;
      out_src   <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      lock_cnt <= cnt_nxt;
      if (load) begin
        out_valid <= grant_any;
        if (grant_any) begin
          out_data <= req_data[grant_idx];
          out_meta <= req_meta[grant_idx];
          out_src  <= grant_idx;
          rr_ptr   <= grant_idx;
        end
      end
    end
  end

endmodule

// File: doc/mdim_rr_sched.md
Name: mdim_rr_sched

Overview:
- Round-robin scheduler that shares one downstream multidim datapath stage (packed byte-array data plus small meta word) between NREQ requesters.
- Sits in front of the child1-style stage. Selects one requester per beat and registers the beat into a single output slot with valid/ready handshake.
- Supports meta-flagged locked bursts, capped at MAX_LOCK beats, so multi-beat packets are not interleaved.

Parameters:
- NREQ, 4, number of requesters (2..16).
- NBYTES, 32, bytes per data beat (outer packed dimension).
- BYTEW, 8, bits per byte (inner packed dimension).
- METAW, 5, meta width; meta[METAW-1] is the lock (continue-burst) flag.
- MAX_LOCK, 8, maximum beats in one locked burst (>=1).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  [NREQ-1:0]  per-requester beat valid.
- req_ready  output  [NREQ-1:0]  per-requester accept; at most one bit set.
- req_data  input  [NREQ-1:0][NBYTES-1:0][BYTEW-1:0]  per-requester data beat.
- req_meta  input  [NREQ-1:0][METAW-1:0]  per-requester meta.
- out_valid  output  1  output slot holds a beat.
- out_ready  input  1  downstream accept.
- out_data  output  [NBYTES-1:0][BYTEW-1:0]  registered data.
- out_meta  output  [METAW-1:0]  registered meta.
- out_src  output  [$clog2(NREQ)-1:0]  index of the requester that supplied the current beat.
- locked  output  1  burst lock active (state LOCKED).

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high.
- Reset values: out_valid=0, out_data=0, out_meta=0, out_src=0, locked=0, state=IDLE, lock_cnt=0, rr_ptr=NREQ-1 (so requester 0 has first priority).
- Slot load condition: load = !out_valid | out_ready. Full throughput of one beat per cycle is allowed when out_ready is held high.
- Grant: combinational. When load is 1 and an eligible requester w has req_valid, drive req_ready = onehot(w). Otherwise req_ready = 0.
  - req_ready never depends on req_valid of a non-winner.
  - Transfer from requester w occurs when req_valid[w] & req_ready[w].
- Capture: a transfer captures req_data[w], req_meta[w] and w into the slot on the next edge, with out_valid=1.
  - If load is 1 and there is no transfer, out_valid becomes 0.
  - If load is 0, the slot holds all values stable (no change while out_valid & !out_ready).
- Latency: 1 cycle from transfer to out_valid.
- Round-robin order: search starts at rr_ptr+1 and wraps modulo NREQ. On every transfer, rr_ptr=w.
- State IDLE: eligible = all requesters.
  - Transfer with lock flag=1 and MAX_LOCK>1: go to LOCKED with owner=w, lock_cnt=1.
  - Otherwise stay in IDLE.
- State LOCKED: eligible = owner only. Other requesters get no grant even if the owner's req_valid is 0; the slot drains and bubbles are allowed.
  - Each owner transfer increments lock_cnt.
  - Return to IDLE, with lock_cnt=0, when the transfer has lock flag=0 or the post-increment lock_cnt==MAX_LOCK.
  - The MAX_LOCK-th beat is accepted and forwarded with its lock flag unchanged.
- locked output = (state==LOCKED), registered.
- Lock transition timing: the IDLE->LOCKED transition takes effect from the cycle after the locking transfer. That cycle's grant already uses owner-only eligibility.
- Meta and data are passed through unmodified. The block performs no arithmetic on payload. lock_cnt is $clog2(MAX_LOCK+1) bits and never wraps.
- Simultaneous events: downstream pop and new capture in the same cycle are legal and produce back-to-back beats. A requester deasserting req_valid without a grant is legal.
- Reset mid-operation (including mid-burst): reset dominates. The slot is discarded, req_ready=0 during reset, and all state returns to its reset values.

Test Plan:
- All four requesters valid, lock flags 0, out_ready=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles; req_ready one-hot each cycle; out_data equals the granted requester's bytes.
- Requester 2 sends meta=5'b10001 twice then 5'b00001, requesters 0/1/3 continuously valid -> out_src 2,2,2 with locked=1 between beats, then the next grant goes to 3; locked=0 after the third beat.
- MAX_LOCK=8, requester 1 holds lock flag=1 for 12 beats -> exactly 8 consecutive beats from 1, then arbitration moves to 2. The 8th beat's out_meta[4]=1.
- out_valid=1 and out_ready=0 for 5 cycles with requester 0 valid -> req_ready=0, out_data/out_meta/out_src stable. On the first out_ready=1 cycle, a transfer occurs and the new beat appears the next cycle.
- Locked to requester 3, which drops req_valid for 3 cycles while requester 0 is valid -> no grants, out_valid falls to 0. Burst resumes from 3 when req_valid[3] returns.
- Assert reset for 1 cycle mid-burst with out_valid=1 -> next cycle out_valid=0, locked=0, out_data=0; the first subsequent grant goes to requester 0.
